demux_scan_ctrl: RTL and testbench
==================================

// Module: demux_scan_ctrl
// PURPOSE
//   Upstream sequencer for demux_1xn. Accepts an N-bit word over a valid/ready handshake.
//   Walks the select S through channels 0..N-1 and presents D = word[S] on each channel
//   for HOLD cycles, so the demux distributes the word bit by bit onto its N outputs.
//   Pulses done after the last channel, then returns to idle for the next word.
// PARAMETERS
//   N     8   channel count; must match demux_1xn N; legal range N >= 2
//   HOLD  1   cycles each channel is held; legal range HOLD >= 1
//   M     $clog2(N)   localparam; width of S
// PORTS
//   clk       in   1   single clock; all state on rising edge
//   rst_n     in   1   asynchronous, active-low reset
//   in_valid  in   1   data_in is valid
//   in_ready  out  1   block can accept a word (high only in IDLE)
//   data_in   in   N   word to distribute; bit i goes to channel i
//   abort     in   1   synchronous cancel of the current scan
//   D         out  1   serial data to demux_1xn D
//   S         out  M   channel select to demux_1xn S
//   en        out  1   D/S are valid this cycle (scan active)
//   busy      out  1   high in SCAN and DONE
//   done      out  1   one-cycle pulse when the final channel has been held
// BEHAVIOUR
//   - Reset (rst_n=0, asynchronous): state=IDLE; D=0, S=0, en=0, busy=0, done=0;
//     shadow word=0; hold count=0. in_ready=1 once rst_n=1.
//   - All outputs are registered, except in_ready, which is decoded from (state==IDLE).
//   - FSM states: IDLE, SCAN, DONE.
//   - IDLE: in_ready=1. On an edge with in_valid&&in_ready:
//     - capture data_in into the shadow register;
//     - set S=0, D=data_in[0], en=1, busy=1, hold count=0;
//     - go to SCAN.
//   - SCAN: en=1. The hold count increments each cycle.
//     - When hold count==HOLD-1 and S<N-1: S<=S+1, D<=word[S+1], hold count<=0.
//     - When hold count==HOLD-1 and S==N-1: go to DONE; en<=0, D<=0, S<=0, done<=1.
//   - DONE: lasts exactly one cycle with done=1, busy=1. Then go to IDLE with done=0, busy=0.
//   - Latency: word accepted at edge k.
//     - en is high for cycles k+1 .. k+N*HOLD.
//     - done is high in cycle k+N*HOLD+1.
//     - The earliest next accept is at the edge ending cycle k+N*HOLD+2 (IDLE).
//   - S counts only 0..N-1. It never reaches values >= N, including for non-power-of-2 N.
//   - in_valid while busy: ignored, because in_ready=0. data_in changes after accept
//     do not affect the scan, which uses the shadow word.
//   - abort sampled high in SCAN or DONE: next state IDLE; D=0, S=0, en=0, busy=0.
//     No done pulse. abort in IDLE has no effect, and abort wins over in_valid on the same edge.
//   - rst_n asserted mid-scan clears immediately (asynchronously); no done pulse is emitted.
// TESTING
//   - Reset: drop rst_n at S=3, mid-scan -> D=0, S=0, en=0, busy=0, done=0
//     before the next clk edge; in_ready=1 after release.
//   - N=8, HOLD=1, data_in=8'b1010_0110:
//     - S=0..7 on 8 consecutive en cycles with D=0,1,1,0,0,1,0,1;
//     - demux_1xn Y = one-hot(S) gated by D each cycle;
//     - done is high in cycle 9 after accept.
//   - HOLD=3, data_in=8'hFF -> each S value is held 3 cycles, giving 24 en cycles;
//     done at cycle 25; D=1 throughout en.
//   - Held handshake: in_valid held at 1 with data_in changed to 8'h00 during the scan.
//     The first word still scans unchanged. 8'h00 is accepted only in IDLE after done,
//     and the scan then restarts at S=0.
//   - abort=1 for one cycle while S=3 -> next cycle IDLE with en=0, D=0, S=0;
//     done never pulses; in_ready=1.
//   - N=5, HOLD=1, data_in=5'b10011 -> S=0..4 with D=1,1,0,0,1, then done;
//     S never takes the values 5, 6 or 7.

Source files
------------

// File: rtl/demux_scan_ctrl.sv
// Sequencer feeding demux_1xn: latches an N-bit word, then walks S over channels 0..N-1
// and presents word[S] on D for HOLD cycles per channel, pulsing done at the end.
module demux_scan_ctrl #(
   parameter int unsigned N    = 8,
   parameter int unsigned HOLD = 1,
   localparam int unsigned M   = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] data_in,
   input  logic         abort,
   output logic         D,
   output logic [M-1:0] S,
   output logic         en,
   output logic         busy,
   output logic         done
);

   localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
   localparam logic [M-1:0]  S_LAST    = M'(N - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]    r_state;
   logic [N-1:0]  r_word;
   logic [HW-1:0] r_hold;
   logic          r_d;
   logic [M-1:0]  r_s;
   logic          r_en;
   logic          r_busy;
   logic          r_done;
   logic [M-1:0]  w_s_next;

   assign w_s_next = r_s + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_word  <= '0;
         r_hold  <= '0;
         r_d     <= 1'b0;
         r_s     <= '0;
         r_en    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // abort on the same edge as a valid word suppresses the accept
               if (in_valid && !abort) begin
                  r_word  <= data_in;
                  r_s     <= '0;
                  r_d     <= data_in[0];
                  r_en    <= 1'b1;
                  r_busy  <= 1'b1;
                  r_hold  <= '0;
                  r_state <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (abort) begin
                  r_state <= ST_IDLE;
                  r_d     <= 1'b0;
                  r_s     <= '0;
                  r_en    <= 1'b0;
                  r_busy  <= 1'b0;
                  r_hold  <= '0;
               end else if (r_hold == HOLD_LAST) begin
                  r_hold <= '0;
                  if (r_s == S_LAST) begin
                     r_state <= ST_DONE;
                     r_en    <= 1'b0;
                     r_d     <= 1'b0;
                     r_s     <= '0;
                     r_done  <= 1'b1;
                  end else begin
                     r_s <= w_s_next;
                     r_d <= r_word[w_s_next];
                  end
               end else begin
                  r_hold <= r_hold + 1'b1;
               end
            end
            ST_DONE: begin
               // single-cycle state; abort here lands in the same place
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_d     <= 1'b0;
               r_s     <= '0;
               r_en    <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_hold  <= '0;
            end
         endcase
      end
   end

   assign in_ready = (r_state == ST_IDLE);
   assign D        = r_d;
   assign S        = r_s;
   assign en       = r_en;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Bench for demux_scan_ctrl: three instances (N8/HOLD1, N8/HOLD3, N5/HOLD1) on shared inputs,
// expected {S,D} beats queued at stimulus time and matched against collected en beats.
module tb_demux_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       abort = 1'b0;

   logic       d8, en8, busy8, done8, rdy8;
   logic [2:0] s8;
   logic       d3, en3, busy3, done3, rdy3;
   logic [2:0] s3;
   logic       d5, en5, busy5, done5, rdy5;
   logic [2:0] s5;

   int         n_cmp = 0;
   int         n_err = 0;
   int         sel = 0;

   logic       obs_d, obs_en, obs_busy, obs_done, obs_rdy;
   logic [2:0] obs_s;

   logic [3:0] exp_q[$];
   logic [3:0] obs_q[$];

   always #5 clk = ~clk;

   demux_scan_ctrl #(.N(8), .HOLD(1)) u_n8h1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8), .data_in(data_in),
      .abort(abort), .D(d8), .S(s8), .en(en8), .busy(busy8), .done(done8)
   );
   demux_scan_ctrl #(.N(8), .HOLD(3)) u_n8h3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy3), .data_in(data_in),
      .abort(abort), .D(d3), .S(s3), .en(en3), .busy(busy3), .done(done3)
   );
   demux_scan_ctrl #(.N(5), .HOLD(1)) u_n5h1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy5), .data_in(data_in[4:0]),
      .abort(abort), .D(d5), .S(s5), .en(en5), .busy(busy5), .done(done5)
   );

   always_comb begin
      obs_d = d8; obs_s = s8; obs_en = en8; obs_busy = busy8; obs_done = done8; obs_rdy = rdy8;
      if (sel == 1) begin
         obs_d = d3; obs_s = s3; obs_en = en3; obs_busy = busy3; obs_done = done3; obs_rdy = rdy3;
      end else if (sel == 2) begin
         obs_d = d5; obs_s = s5; obs_en = en5; obs_busy = busy5; obs_done = done5; obs_rdy = rdy5;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; abort = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic accept(input logic [7:0] w, input bit keep_valid);
      @(negedge clk);
      in_valid = 1'b1; data_in = w;
      @(posedge clk);
      #1;
      if (!keep_valid) in_valid = 1'b0;
   endtask

   // queue the per-beat {S,D} the selected instance must produce for word w
   task automatic push_expected(input logic [7:0] w, input int n, input int hold);
      for (int ch = 0; ch < n; ch++)
         for (int h = 0; h < hold; h++) exp_q.push_back({3'(ch), w[ch]});
   endtask

   // records en beats of the selected instance; cycle 1 is the cycle after the call's edge
   task automatic collect(input int budget, output int done_cyc, output int en_cnt,
                          output int rdy_in_scan, output logic busy_at_done);
      done_cyc = -1; en_cnt = 0; rdy_in_scan = 0; busy_at_done = 1'b0;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         if (obs_en) begin
            obs_q.push_back({obs_s, obs_d});
            en_cnt++;
            if (obs_rdy) rdy_in_scan++;
         end
         if (obs_done) begin
            done_cyc = c;
            busy_at_done = obs_busy;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [3:0] e;
      int done_seen;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({d8, s8, en8, busy8, done8} !== 7'b0) begin
         n_err++; $display("FAIL reset_values: got %b want 0000000", {d8, s8, en8, busy8, done8});
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (rdy8 !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", rdy8); end
      sel = 0;
      accept(8'hA6, 1'b0);
      e = '0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (en8 && s8 == 3'd3) begin e = 4'hF; break; end
      end
      n_cmp++;
      if (e !== 4'hF) begin n_err++; $display("FAIL reset_reach_s3: got %h want f", e); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({d8, s8, en8, busy8, done8} !== 7'b0) begin
         n_err++; $display("FAIL reset_async_clear: got %b want 0000000", {d8, s8, en8, busy8, done8});
      end
      #1 rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({rdy8, en8} !== 2'b10) begin
         n_err++; $display("FAIL reset_release: got rdy/en %b want 10", {rdy8, en8});
      end
      done_seen = 0;
      repeat (12) begin @(negedge clk); if (done8) done_seen++; end
      n_cmp++;
      if (done_seen !== 0) begin n_err++; $display("FAIL reset_no_done: got %0d want 0", done_seen); end
   endtask

   // pops scoreboard pairs and checks nothing is left over on either side
   task automatic test_scan(input string name, input int s, input logic [7:0] w, input int n,
                            input int hold);
      int dc, ec, rb;
      logic bd;
      logic [3:0] e, o;
      do_reset();
      sel = s;
      push_expected(w, n, hold);
      accept(w, 1'b0);
      collect(n * hold + 10, dc, ec, rb, bd);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_err++; $display("FAIL %s_beat: got none want S=%0d D=%b", name, e[3:1], e[0]);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_err++;
               $display("FAIL %s_beat: got S=%0d D=%b want S=%0d D=%b", name, o[3:1], o[0], e[3:1], e[0]);
            end
         end
      end
      n_cmp++;
      if (obs_q.size() != 0) begin
         n_err++; $display("FAIL %s_extra_beats: got %0d want 0", name, obs_q.size());
      end
      n_cmp++;
      if (dc != n * hold + 1) begin
         n_err++; $display("FAIL %s_done_cycle: got %0d want %0d", name, dc, n * hold + 1);
      end
      n_cmp++;
      if (ec != n * hold || rb != 0 || bd !== 1'b1) begin
         n_err++;
         $display("FAIL %s_en_count: got en=%0d rdy_in_scan=%0d busy@done=%b want %0d 0 1",
                  name, ec, rb, bd, n * hold);
      end
      @(negedge clk);
      n_cmp++;
      if ({obs_rdy, obs_busy, obs_done} !== 3'b100) begin
         n_err++; $display("FAIL %s_back_idle: got %b want 100", name, {obs_rdy, obs_busy, obs_done});
      end
   endtask

   task automatic test_back_to_back();
      int dc, ec, rb;
      logic bd;
      logic [3:0] e, o;
      do_reset();
      sel = 0;
      push_expected(8'hA6, 8, 1);
      accept(8'hA6, 1'b1);
      data_in = 8'h00;
      collect(20, dc, ec, rb, bd);
      n_cmp++;
      if (dc != 9) begin n_err++; $display("FAIL b2b_first_done: got %0d want 9", dc); end
      push_expected(8'h00, 8, 1);
      // one IDLE cycle, accept at its end, 8 beats, then done
      collect(20, dc, ec, rb, bd);
      in_valid = 1'b0;
      n_cmp++;
      if (dc != 10 || ec != 8) begin
         n_err++; $display("FAIL b2b_second_done: got done=%0d en=%0d want 10 8", dc, ec);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 4'hF;
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL b2b_beat: got S=%0d D=%b want S=%0d D=%b", o[3:1], o[0], e[3:1], e[0]);
         end
      end
   endtask

   task automatic test_abort();
      int done_seen, en_seen;
      logic hit;
      do_reset();
      sel = 0;
      accept(8'hA6, 1'b0);
      hit = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (en8 && s8 == 3'd3) begin hit = 1'b1; break; end
      end
      n_cmp++;
      if (hit !== 1'b1) begin n_err++; $display("FAIL abort_reach_s3: got %b want 1", hit); end
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({en8, d8, s8, busy8, rdy8} !== 7'b0000001) begin
         n_err++; $display("FAIL abort_idle: got %b want 0000001", {en8, d8, s8, busy8, rdy8});
      end
      done_seen = 0;
      repeat (12) begin @(negedge clk); if (done8) done_seen++; end
      n_cmp++;
      if (done_seen !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d want 0", done_seen); end
      // abort and in_valid together in IDLE: no accept
      @(negedge clk);
      abort = 1'b1; in_valid = 1'b1; data_in = 8'hFF;
      @(posedge clk);
      #1 abort = 1'b0; in_valid = 1'b0;
      en_seen = 0;
      repeat (3) begin @(negedge clk); if (en8 || busy8) en_seen++; end
      n_cmp++;
      if (en_seen !== 0 || rdy8 !== 1'b1) begin
         n_err++; $display("FAIL abort_beats_valid: got busy_cycles=%0d rdy=%b want 0 1", en_seen, rdy8);
      end
   endtask

   initial begin
      test_reset();
      test_scan("n8h1", 0, 8'b1010_0110, 8, 1);
      test_scan("n8h3", 1, 8'hFF, 8, 3);
      test_scan("n5h1", 2, 8'b0001_0011, 5, 1);
      test_back_to_back();
      test_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
